hash_out_serializer: RTL

//  Output side of the byte-wide I/O interface: the complement of the config/data

---
 rtl/hash_out_serializer.sv | 118 +++++++++++
 1 files changed

// File: rtl/hash_out_serializer.sv
// Digest output serializer: captures a 64-byte BLAKE2b digest and streams the first nn bytes out LSB-byte first.
// Optional downstream flow control is enabled by defining HASH_OUT_READY_EN (adds the ready_i port).
module hash_out_serializer #(
    parameter int NN_MAX = 64,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  hash_v_i,
    input  logic [8*NN_MAX-1:0]   hash_i,
    input  logic [7:0]            nn_i,
`ifdef HASH_OUT_READY_EN
    input  logic                  ready_i,
`endif
    output logic                  hash_v_o,
    output logic [7:0]            hash_o,
    output logic [IDX_W-1:0]      hash_idx_o,
    output logic                  hash_last_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam logic [7:0] NN_MAX_B = 8'(NN_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                state_r;
    logic [8*NN_MAX-1:0]   shift_r;
    logic [7:0]            nn_q_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  last_r;
    logic                  overrun_r;

    logic                  ready_s;
    logic                  accept_s;
    logic                  last_acc_s;
    logic                  capture_s;
    logic [7:0]            nn_eff_s;

    // Handshake decode and digest-length clamping for the next capture.
    always_comb begin
`ifdef HASH_OUT_READY_EN
        ready_s = ready_i;
`else
        ready_s = 1'b1;
`endif
        accept_s   = (state_r == ST_SEND) & ready_s;
        last_acc_s = accept_s & last_r;
        // A new digest may land in the same cycle the previous stream's last byte leaves.
        capture_s  = hash_v_i & ((state_r == ST_IDLE) | last_acc_s);
        if ((nn_i == 8'd0) || (nn_i > NN_MAX_B)) begin
            nn_eff_s = NN_MAX_B;
        end else begin
            nn_eff_s = nn_i;
        end
    end

    // Serializer FSM together with its datapath and registered status flags.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            nn_q_r    <= 8'd0;
            idx_r     <= '0;
            last_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= hash_v_i & (state_r == ST_SEND) & ~last_acc_s;
            if (capture_s) begin
                state_r <= ST_SEND;
                shift_r <= hash_i;
                nn_q_r  <= nn_eff_s;
                idx_r   <= '0;
                last_r  <= (nn_eff_s == 8'd1);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_SEND: begin
                        if (last_acc_s) begin
                            // Clear the datapath so idle outputs read as zero.
                            state_r <= ST_IDLE;
                            shift_r <= '0;
                            nn_q_r  <= 8'd0;
                            idx_r   <= '0;
                            last_r  <= 1'b0;
                        end else if (accept_s) begin
                            shift_r <= shift_r >> 8;
                            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                            last_r  <= ((8'(idx_r) + 8'd2) == nn_q_r);
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        shift_r <= '0;
                        nn_q_r  <= 8'd0;
                        idx_r   <= '0;
                        last_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hash_v_o    = (state_r == ST_SEND);
    assign busy_o      = (state_r == ST_SEND);
    assign hash_o      = shift_r[7:0];
    assign hash_idx_o  = idx_r;
    assign hash_last_o = last_r;
    assign overrun_o   = overrun_r;

endmodule
